// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: access-size codes, FSM state
// encoding and the size/lane-mask helpers used by the request decoder.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_D  = 3'b011;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [2:0] F3_WU = 3'b110;

  typedef enum logic [1:0] {
    IDLE,
    ACC1,
    ACC2,
    RESP
  } state_t;

  // Access size in bytes; 0 marks a code that is never legal.
  function automatic logic [3:0] size_bytes(input logic [2:0] funct3);
    case (funct3)
      F3_B, F3_BU: return 4'd1;
      F3_H, F3_HU: return 4'd2;
      F3_W, F3_WU: return 4'd4;
      F3_D:        return 4'd8;
      default:     return 4'd0;
    endcase
  endfunction

  // Byte mask over two consecutive bus words (2*nb bits, nb <= 8).
  function automatic logic [15:0] lane_mask(input int unsigned off,
                                            input int unsigned size,
                                            input int unsigned nb);
    logic [15:0] ones;
    logic [15:0] limit;
    ones  = (16'd1 << size) - 16'd1;
    limit = (nb >= 8) ? 16'hFFFF : ((16'd1 << (2 * nb)) - 16'd1);
    return (ones << off) & limit;
  endfunction

endpackage

// File: rtl/lsu_extend.sv
// Load alignment: shifts the two-word read buffer down to the access offset,
// truncates to the access size and sign- or zero-extends to XLEN.
module lsu_extend
  import lsu_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [2*XLEN-1:0]          rdata_buf,
  input  logic [$clog2(XLEN/8)-1:0]  off,
  input  logic [2:0]                 funct3,
  output logic [XLEN-1:0]            result
);

  logic [XLEN-1:0] shifted;

  always_comb begin
    shifted = XLEN'(rdata_buf >> {off, 3'b000});
    result  = '0;
    case (funct3)
      F3_B:    result = XLEN'($signed(shifted[7:0]));
      F3_H:    result = XLEN'($signed(shifted[15:0]));
      F3_W:    result = XLEN'($signed(shifted[31:0]));
      F3_D:    result = shifted;
      F3_BU:   result = XLEN'(shifted[7:0]);
      F3_HU:   result = XLEN'(shifted[15:0]);
      F3_WU:   result = XLEN'(shifted[31:0]);
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// MEM-stage load/store unit: captures one request, runs one or two bus
// transfers with ready handshake, and returns an extended load result.
module lsu
  import lsu_pkg::*;
#(
  parameter int unsigned XLEN             = 32,
  parameter bit          ALLOW_MISALIGNED = 1'b1
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              MemReqM,
  input  logic              MemWriteM,
  input  logic [2:0]        funct3M,
  input  logic [XLEN-1:0]   AddrM,
  input  logic [XLEN-1:0]   WriteDataM,
  output logic [XLEN-1:0]   LoadDataM,
  output logic              DoneM,
  output logic              FaultM,
  output logic              StallM,
  output logic              memReq,
  output logic              memWe,
  output logic [XLEN-1:0]   memAddr,
  output logic [XLEN-1:0]   memWData,
  output logic [XLEN/8-1:0] memByteEn,
  input  logic [XLEN-1:0]   memRData,
  input  logic              memReady
);

  localparam int unsigned NB = XLEN / 8;
  localparam int unsigned OW = $clog2(NB);

  state_t state, state_d;

  // Captured request
  logic [XLEN-1:0]   base_q;
  logic [OW-1:0]     off_q;
  logic [2:0]        f3_q;
  logic              we_q;
  logic              fault_q;
  logic              cross_q;
  logic [2*NB-1:0]   mask_q;
  logic [2*XLEN-1:0] wsh_q;
  logic [2*XLEN-1:0] rbuf_q;

  // Request decode
  logic [OW-1:0]     off_in;
  logic [3:0]        size_in;
  logic              illegal_in;
  logic              cross_in;
  logic              fault_in;
  logic [XLEN-1:0]   base_in;
  logic [2*NB-1:0]   mask_in;
  logic [2*XLEN-1:0] wsh_in;

  // Next bus-register values
  logic              capture;
  logic              xfer;
  logic              req_d;
  logic              we_d;
  logic [XLEN-1:0]   addr_d;
  logic [XLEN-1:0]   wdata_d;
  logic [NB-1:0]     be_d;

  logic [XLEN-1:0]   ext;

  always_comb begin
    off_in     = AddrM[OW-1:0];
    size_in    = size_bytes(funct3M);
    illegal_in = (size_in == 4'd0) ||
                 ((XLEN == 32) && ((funct3M == F3_D) || (funct3M == F3_WU)));
    cross_in   = (5'(off_in) + 5'(size_in)) > 5'(NB);
    fault_in   = illegal_in || (cross_in && !ALLOW_MISALIGNED);
    base_in    = AddrM & ~XLEN'(NB - 1);
    mask_in    = (2*NB)'(lane_mask(32'(off_in), 32'(size_in), NB));
    wsh_in     = {{XLEN{1'b0}}, WriteDataM} << {off_in, 3'b000};
  end

  assign xfer = memReq & memReady;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) state <= IDLE;
    else     state <= state_d;
  end

  // Bus outputs are registered from these next values, so they hold steady
  // through wait states simply by defaulting to their current values.
  always_comb begin
    state_d = state;
    capture = 1'b0;
    req_d   = memReq;
    we_d    = memWe;
    addr_d  = memAddr;
    wdata_d = memWData;
    be_d    = memByteEn;
    case (state)
      IDLE: begin
        if (MemReqM) begin
          capture = 1'b1;
          if (fault_in) begin
            state_d = RESP;
          end else begin
            state_d = ACC1;
            req_d   = 1'b1;
            we_d    = MemWriteM;
            addr_d  = base_in;
            wdata_d = wsh_in[XLEN-1:0];
            be_d    = mask_in[NB-1:0];
          end
        end
      end
      ACC1: begin
        if (xfer) begin
          if (cross_q) begin
            state_d = ACC2;
            addr_d  = base_q + XLEN'(NB);
            wdata_d = wsh_q[2*XLEN-1:XLEN];
            be_d    = mask_q[2*NB-1:NB];
          end else begin
            state_d = RESP;
            req_d   = 1'b0;
            we_d    = 1'b0;
            addr_d  = '0;
            wdata_d = '0;
            be_d    = '0;
          end
        end
      end
      ACC2: begin
        if (xfer) begin
          state_d = RESP;
          req_d   = 1'b0;
          we_d    = 1'b0;
          addr_d  = '0;
          wdata_d = '0;
          be_d    = '0;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      memReq    <= 1'b0;
      memWe     <= 1'b0;
      memAddr   <= '0;
      memWData  <= '0;
      memByteEn <= '0;
      base_q    <= '0;
      off_q     <= '0;
      f3_q      <= '0;
      we_q      <= 1'b0;
      fault_q   <= 1'b0;
      cross_q   <= 1'b0;
      mask_q    <= '0;
      wsh_q     <= '0;
      rbuf_q    <= '0;
    end else begin
      memReq    <= req_d;
      memWe     <= we_d;
      memAddr   <= addr_d;
      memWData  <= wdata_d;
      memByteEn <= be_d;
      if (capture) begin
        base_q  <= base_in;
        off_q   <= off_in;
        f3_q    <= funct3M;
        we_q    <= MemWriteM;
        fault_q <= fault_in;
        cross_q <= cross_in;
        mask_q  <= mask_in;
        wsh_q   <= wsh_in;
        rbuf_q  <= '0;
      end
      if ((state == ACC1) && xfer) rbuf_q[XLEN-1:0]      <= memRData;
      if ((state == ACC2) && xfer) rbuf_q[2*XLEN-1:XLEN] <= memRData;
    end
  end

  lsu_extend #(.XLEN(XLEN)) u_extend (
    .rdata_buf (rbuf_q),
    .off       (off_q),
    .funct3    (f3_q),
    .result    (ext)
  );

  assign DoneM     = (state == RESP);
  assign FaultM    = DoneM & fault_q;
  assign StallM    = MemReqM & ~DoneM;
  assign LoadDataM = (DoneM && !we_q && !fault_q) ? ext : '0;

endmodule

// File: tb/tb_lsu.sv
// Directed bench for lsu: three instances (32-bit split, 32-bit faulting,
// 64-bit) exercised by one linear sequence with hand-computed expectations.
module tb_lsu;

  logic clk;
  logic clr;

  // a: XLEN=32, ALLOW_MISALIGNED=1
  logic        a_req, a_wr, a_done, a_fault, a_stall, a_mreq, a_mwe, a_rdy;
  logic [2:0]  a_f3;
  logic [31:0] a_addr, a_wdata, a_load, a_maddr, a_mwdata, a_rdata;
  logic [3:0]  a_be;

  // b: XLEN=32, ALLOW_MISALIGNED=0
  logic        b_req, b_wr, b_done, b_fault, b_stall, b_mreq, b_mwe, b_rdy;
  logic [2:0]  b_f3;
  logic [31:0] b_addr, b_wdata, b_load, b_maddr, b_mwdata, b_rdata;
  logic [3:0]  b_be;

  // c: XLEN=64, ALLOW_MISALIGNED=1
  logic        c_req, c_wr, c_done, c_fault, c_stall, c_mreq, c_mwe, c_rdy;
  logic [2:0]  c_f3;
  logic [63:0] c_addr, c_wdata, c_load, c_maddr, c_mwdata, c_rdata;
  logic [7:0]  c_be;

  int n_assert;
  int n_fail;

  lsu #(.XLEN(32), .ALLOW_MISALIGNED(1'b1)) u_a (
    .clk(clk), .clr(clr), .MemReqM(a_req), .MemWriteM(a_wr), .funct3M(a_f3),
    .AddrM(a_addr), .WriteDataM(a_wdata), .LoadDataM(a_load), .DoneM(a_done),
    .FaultM(a_fault), .StallM(a_stall), .memReq(a_mreq), .memWe(a_mwe),
    .memAddr(a_maddr), .memWData(a_mwdata), .memByteEn(a_be),
    .memRData(a_rdata), .memReady(a_rdy)
  );

  lsu #(.XLEN(32), .ALLOW_MISALIGNED(1'b0)) u_b (
    .clk(clk), .clr(clr), .MemReqM(b_req), .MemWriteM(b_wr), .funct3M(b_f3),
    .AddrM(b_addr), .WriteDataM(b_wdata), .LoadDataM(b_load), .DoneM(b_done),
    .FaultM(b_fault), .StallM(b_stall), .memReq(b_mreq), .memWe(b_mwe),
    .memAddr(b_maddr), .memWData(b_mwdata), .memByteEn(b_be),
    .memRData(b_rdata), .memReady(b_rdy)
  );

  lsu #(.XLEN(64), .ALLOW_MISALIGNED(1'b1)) u_c (
    .clk(clk), .clr(clr), .MemReqM(c_req), .MemWriteM(c_wr), .funct3M(c_f3),
    .AddrM(c_addr), .WriteDataM(c_wdata), .LoadDataM(c_load), .DoneM(c_done),
    .FaultM(c_fault), .StallM(c_stall), .memReq(c_mreq), .memWe(c_mwe),
    .memAddr(c_maddr), .memWData(c_mwdata), .memByteEn(c_be),
    .memRData(c_rdata), .memReady(c_rdy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    clr = 1'b1;
    a_req = 0; a_wr = 0; a_f3 = 3'b000; a_addr = '0; a_wdata = '0; a_rdata = '0; a_rdy = 1'b1;
    b_req = 0; b_wr = 0; b_f3 = 3'b000; b_addr = '0; b_wdata = '0; b_rdata = 32'h12345678; b_rdy = 1'b1;
    c_req = 0; c_wr = 0; c_f3 = 3'b000; c_addr = '0; c_wdata = '0; c_rdata = '0; c_rdy = 1'b0;
    tick;
    tick;

    // Reset values (memReady high while idle must be ignored)
    chk("rst_memreq",  64'(a_mreq), 64'd0);
    chk("rst_memaddr", 64'(a_maddr), 64'd0);
    chk("rst_byteen",  64'(a_be), 64'd0);
    chk("rst_done",    64'(a_done), 64'd0);
    chk("rst_load",    64'(a_load), 64'd0);
    chk("rst_c_mwd",   c_mwdata, 64'd0);
    clr = 1'b0;
    tick;
    chk("idle_memreq", 64'(a_mreq), 64'd0);

    // lw 0x100, zero wait states
    a_req = 1; a_wr = 0; a_f3 = 3'b010; a_addr = 32'h100; a_rdata = 32'hDEADBEEF;
    #1;
    chk("lw_stall_c0", 64'(a_stall), 64'd1);
    tick;
    chk("lw_memreq",   64'(a_mreq), 64'd1);
    chk("lw_memaddr",  64'(a_maddr), 64'h100);
    chk("lw_byteen",   64'(a_be), 64'hF);
    chk("lw_memwe",    64'(a_mwe), 64'd0);
    chk("lw_stall_c1", 64'(a_stall), 64'd1);
    chk("lw_done_c1",  64'(a_done), 64'd0);
    tick;
    chk("lw_done_c2",  64'(a_done), 64'd1);
    chk("lw_load",     64'(a_load), 64'hDEADBEEF);
    chk("lw_stall_c2", 64'(a_stall), 64'd0);
    chk("lw_fault",    64'(a_fault), 64'd0);
    chk("lw_memreq_c2", 64'(a_mreq), 64'd0);
    tick;
    chk("lw_done_c3",  64'(a_done), 64'd0);
    a_req = 0;
    tick;

    // lb / lbu at 0x103
    a_req = 1; a_f3 = 3'b000; a_addr = 32'h103; a_rdata = 32'h80123456;
    tick;
    chk("lb_byteen",   64'(a_be), 64'h8);
    chk("lb_memaddr",  64'(a_maddr), 64'h100);
    tick;
    chk("lb_load",     64'(a_load), 64'hFFFFFF80);
    a_req = 0;
    tick;
    a_req = 1; a_f3 = 3'b100;
    tick;
    tick;
    chk("lbu_load",    64'(a_load), 64'h00000080);
    a_req = 0;
    tick;

    // lh at 0x101: misaligned but not crossing
    a_req = 1; a_f3 = 3'b001; a_addr = 32'h101; a_rdata = 32'h00ABCD00;
    tick;
    chk("lh_byteen",   64'(a_be), 64'h6);
    tick;
    chk("lh_load",     64'(a_load), 64'hFFFFABCD);
    a_req = 0;
    tick;

    // sw 0x11223344 at 0x102, split into two transfers
    a_req = 1; a_wr = 1; a_f3 = 3'b010; a_addr = 32'h102; a_wdata = 32'h11223344;
    tick;
    chk("sw1_memaddr", 64'(a_maddr), 64'h100);
    chk("sw1_byteen",  64'(a_be), 64'hC);
    chk("sw1_wdata",   64'(a_mwdata), 64'h33440000);
    chk("sw1_memwe",   64'(a_mwe), 64'd1);
    tick;
    chk("sw2_memaddr", 64'(a_maddr), 64'h104);
    chk("sw2_byteen",  64'(a_be), 64'h3);
    chk("sw2_wdata",   64'(a_mwdata), 64'h00001122);
    chk("sw2_done",    64'(a_done), 64'd0);
    tick;
    chk("sw_done",     64'(a_done), 64'd1);
    chk("sw_load",     64'(a_load), 64'd0);
    chk("sw_memreq",   64'(a_mreq), 64'd0);
    tick;
    chk("sw_done_once", 64'(a_done), 64'd0);
    a_req = 0; a_wr = 0;
    tick;

    // Split lw at 0x102 with distinct words
    a_req = 1; a_f3 = 3'b010; a_addr = 32'h102; a_rdata = 32'hAABBCCDD;
    tick;
    tick;
    a_rdata = 32'h11223344;
    tick;
    chk("slw_load",    64'(a_load), 64'h3344AABB);
    a_req = 0;
    tick;

    // funct3=111 faults even when misalignment is allowed
    a_req = 1; a_f3 = 3'b111; a_addr = 32'h0;
    tick;
    chk("f111_fault",  64'(a_fault), 64'd1);
    chk("f111_memreq", 64'(a_mreq), 64'd0);
    a_req = 0;
    tick;

    // clr during ACC2 of a split load
    a_req = 1; a_f3 = 3'b010; a_addr = 32'h102; a_rdata = 32'h55555555;
    tick;
    tick;
    chk("clr_pre_req",  64'(a_mreq), 64'd1);
    chk("clr_pre_addr", 64'(a_maddr), 64'h104);
    clr = 1'b1; a_req = 0;
    #1;
    chk("clr_memreq",  64'(a_mreq), 64'd0);
    chk("clr_byteen",  64'(a_be), 64'd0);
    chk("clr_done",    64'(a_done), 64'd0);
    tick;
    clr = 1'b0;
    tick;
    chk("clr_nodone",  64'(a_done), 64'd0);
    a_req = 1; a_f3 = 3'b010; a_addr = 32'h200; a_rdata = 32'hCAFEF00D;
    tick;
    chk("post_memaddr", 64'(a_maddr), 64'h200);
    tick;
    chk("post_done",   64'(a_done), 64'd1);
    chk("post_load",   64'(a_load), 64'hCAFEF00D);
    a_req = 0;
    tick;

    // No-misaligned instance: crossing lw faults, illegal size faults
    b_req = 1; b_f3 = 3'b010; b_addr = 32'h3;
    tick;
    chk("b_lw3_done",  64'(b_done), 64'd1);
    chk("b_lw3_fault", 64'(b_fault), 64'd1);
    chk("b_lw3_memreq", 64'(b_mreq), 64'd0);
    chk("b_lw3_load",  64'(b_load), 64'd0);
    b_req = 0;
    tick;
    chk("b_lw3_memreq2", 64'(b_mreq), 64'd0);
    b_req = 1; b_f3 = 3'b011; b_addr = 32'h0;
    tick;
    chk("b_ld_fault",  64'(b_fault), 64'd1);
    chk("b_ld_memreq", 64'(b_mreq), 64'd0);
    b_req = 0;
    tick;
    b_req = 1; b_f3 = 3'b101; b_addr = 32'h1;
    tick;
    chk("b_lhu_memreq", 64'(b_mreq), 64'd1);
    tick;
    chk("b_lhu_fault", 64'(b_fault), 64'd0);
    chk("b_lhu_load",  64'(b_load), 64'h00003456);
    b_req = 0;
    tick;

    // 64-bit ld at 0x8 with three wait cycles
    c_req = 1; c_f3 = 3'b011; c_addr = 64'h8; c_rdy = 1'b0; c_rdata = 64'h0123456789ABCDEF;
    tick;
    chk("c_ld_memreq1", 64'(c_mreq), 64'd1);
    chk("c_ld_addr1",  c_maddr, 64'h8);
    chk("c_ld_be1",    64'(c_be), 64'hFF);
    tick;
    chk("c_ld_memreq2", 64'(c_mreq), 64'd1);
    chk("c_ld_addr2",  c_maddr, 64'h8);
    tick;
    chk("c_ld_be3",    64'(c_be), 64'hFF);
    chk("c_ld_stall3", 64'(c_stall), 64'd1);
    tick;
    chk("c_ld_done4",  64'(c_done), 64'd0);
    chk("c_ld_memreq4", 64'(c_mreq), 64'd1);
    c_rdy = 1'b1;
    tick;
    chk("c_ld_done5",  64'(c_done), 64'd1);
    chk("c_ld_load",   c_load, 64'h0123456789ABCDEF);
    c_req = 0;
    tick;

    // 64-bit lw / lwu at 0x4
    c_req = 1; c_f3 = 3'b010; c_addr = 64'h4; c_rdata = 64'h8765432100000000;
    tick;
    chk("c_lw_be",     64'(c_be), 64'hF0);
    tick;
    chk("c_lw_load",   c_load, 64'hFFFFFFFF87654321);
    c_req = 0;
    tick;
    c_req = 1; c_f3 = 3'b110;
    tick;
    tick;
    chk("c_lwu_load",  c_load, 64'h0000000087654321);
    c_req = 0;
    tick;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/lsu.md
# lsu

Parametrised load/store unit replacing the fixed 32-bit byte-enable/load-extend logic in the MEM stage of the rv32i pipeline. It supports XLEN 32 or 64 and a memory port with a ready handshake (wait states). It optionally splits misaligned accesses that cross a bus-word boundary into two bus transfers. While an access is in flight it stalls the pipeline and returns one sign/zero-extended load result.

## Interface
Parameters:
- XLEN, 32, data/address width; legal values 32 or 64; NB = XLEN/8 bytes per bus word
- ALLOW_MISALIGNED, 1, 1 = split boundary-crossing accesses; 0 = report fault, no bus access

Ports (clock and reset first):
- clk  in  1  single clock, rising edge
- clr  in  1  reset, asynchronous, active-high
- MemReqM  in  1  load or store present in MEM stage
- MemWriteM  in  1  1 = store, 0 = load
- funct3M  in  3  000 b, 001 h, 010 w, 011 d, 100 bu, 101 hu, 110 wu
- AddrM  in  XLEN  byte address
- WriteDataM  in  XLEN  store data, right-aligned
- LoadDataM  out  XLEN  extended load result, valid while DoneM
- DoneM  out  1  one-cycle completion pulse
- FaultM  out  1  with DoneM: misaligned (when ALLOW_MISALIGNED=0) or illegal size
- StallM  out  1  combinational: MemReqM & ~DoneM
- memReq  out  1  bus request, registered
- memWe  out  1  bus write, valid with memReq
- memAddr  out  XLEN  NB-aligned bus address
- memWData  out  XLEN  lane-positioned store data
- memByteEn  out  NB  byte lane enables
- memRData  in  XLEN  read data, valid in the memReady cycle
- memReady  in  1  transfer completes at the edge where memReq & memReady

## Operation
- Size: b=1, h=2, w=4, d=8 bytes. Codes 011/110 are illegal when XLEN=32; code 111 is always illegal.
- off = AddrM mod NB. Misaligned = AddrM mod size ≠ 0. Crossing = off + size > NB.
- FSM states: IDLE, ACC1, ACC2, RESP.
- IDLE: on MemReqM, capture address, data, funct3 and write flag.
  - Illegal size, or crossing with ALLOW_MISALIGNED=0 → RESP with fault set.
  - Otherwise → ACC1.
- Misaligned but not crossing (e.g. h at off 1, XLEN=32) is a single legal access.
- ACC1: memAddr = AddrM & ~(NB-1); memByteEn bits off..min(off+size-1, NB-1).
  - On memReady: latch memRData into the low buffer half.
  - Go to ACC2 if crossing, else RESP.
- ACC2: memAddr = first address + NB; memByteEn bits 0..(off+size-1-NB).
  - On memReady: latch memRData into the high half; go to RESP.
- Store data: WriteDataM is zero-extended to 2·XLEN and shifted left by 8·off. The low half drives ACC1, the high half drives ACC2.
- Load data: the 2·XLEN buffer is shifted right by 8·off, truncated to size, then sign-extended (000/001/010/011) or zero-extended (100/101/110).
- RESP: DoneM=1, StallM=0 so the pipeline advances; always → IDLE. It never re-captures, even though MemReqM is still high.
- LoadDataM = 0 for stores and faults. A faulted store performs no bus write.
- memReq/memWe stay asserted, with all bus outputs stable, until memReady is seen.

## Timing
- Aligned access with zero wait states: capture in cycle 0, transfer in cycle 1, DoneM in cycle 2. StallM is high in cycles 0–1.
- Each wait cycle (memReady low) adds one cycle. A split access adds one transfer.
- Fault: DoneM one cycle after capture, with memReq never asserted.
- Reset values: state IDLE; memReq, memWe, memAddr, memWData, memByteEn, LoadDataM, DoneM, FaultM all 0.
- clr asserted mid-access: immediate return to IDLE and memReq drops in the same cycle. The partial split is abandoned and no DoneM is issued.
- memReady while memReq=0 is ignored.

## Structure
- Package lsu_pkg holds:
  - size code constants and the state enum;
  - function size_bytes(funct3);
  - function lane_mask(off, size, NB), which returns the 2·NB-bit byte mask.
- One sub-module, lsu_extend (parametrised by XLEN): combinational shift/truncate/extend of the 2·XLEN buffer.
- The FSM, capture registers and bus drivers live in lsu.

## Test plan
- XLEN=32, lw at 0x100, memRData=0xDEADBEEF, memReady tied high → memAddr=0x100, memByteEn=1111; DoneM at cycle 2; LoadDataM=0xDEADBEEF; StallM high 2 cycles.
- XLEN=32, lb at 0x103, memRData=0x80XXXXXX → memByteEn=1000, LoadDataM=0xFFFFFF80. Same access as lbu → 0x00000080.
- XLEN=32, ALLOW_MISALIGNED=1, sw 0x11223344 at 0x102 → ACC1: addr 0x100, byteEn=1100, wdata=0x33440000. ACC2: addr 0x104, byteEn=0011, wdata=0x00001122. DoneM once.
- XLEN=64, ld at 0x8 with memReady low 3 cycles → memReq held with outputs stable; DoneM 5 cycles after capture; full 64-bit data returned.
- ALLOW_MISALIGNED=0, lw at 0x3 → FaultM=DoneM=1 one cycle after capture; memReq never asserted. XLEN=32 with funct3=011 → same fault.
- clr pulsed during ACC2 of a split load → memReq 0 immediately, state IDLE, no DoneM. The next aligned load completes normally.
